// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: the bundle of signals between the result producers and the
// common data bus arbiter.
//
// Producer/control side (master drives, arbiter samples):
//   rdy, in_clear         global enable and pipeline flush
//   in_alu_tag/value      ALU result; a nonzero tag marks a valid result
//   in_lsb_valid/tag/value load/store buffer result, held until granted
// Arbiter side (slave drives, master samples):
//   out_lsb_grant         LSB result accepted this cycle
//   out_alu_stall         reservation stations must not issue ALU ops
//   out_cdb_tag/value     registered broadcast; tag 0 means idle
interface cdb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              rdy;
    logic              in_clear;
    logic [TAG_W-1:0]  in_alu_tag;
    logic [DATA_W-1:0] in_alu_value;
    logic              in_lsb_valid;
    logic [TAG_W-1:0]  in_lsb_tag;
    logic [DATA_W-1:0] in_lsb_value;
    logic              out_lsb_grant;
    logic              out_alu_stall;
    logic [TAG_W-1:0]  out_cdb_tag;
    logic [DATA_W-1:0] out_cdb_value;

    modport master (
        output rdy, in_clear, in_alu_tag, in_alu_value,
               in_lsb_valid, in_lsb_tag, in_lsb_value,
        input  out_lsb_grant, out_alu_stall, out_cdb_tag, out_cdb_value
    );

    modport slave (
        input  rdy, in_clear, in_alu_tag, in_alu_value,
               in_lsb_valid, in_lsb_tag, in_lsb_value,
        output out_lsb_grant, out_alu_stall, out_cdb_tag, out_cdb_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates the common data bus between an ALU (which cannot be
// stalled, so its results are absorbed by a small skid FIFO) and the
// load/store buffer (which holds its request until granted). The winner is
// broadcast one clock edge later on out_cdb_tag/out_cdb_value.
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous reset, active low; overrides rdy and in_clear
//   bus  cdb_arbiter_if.slave (inputs, grant, stall and broadcast outputs)
//
// DEPTH must be at least 2.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    cdb_arbiter_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);
    localparam logic [TAG_W-1:0] TAG_NONE  = {TAG_W{1'b0}};

    // Which requester was granted most recently; the other one wins a tie.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSB = 1'b1
    } grant_e;

    // Pointer advance with wrap at DEPTH (works for non-power-of-two depths).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
    endfunction

    logic [TAG_W-1:0]  fifo_tag_r [DEPTH];
    logic [DATA_W-1:0] fifo_val_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    grant_e            last_grant_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [DATA_W-1:0] cdb_val_r;

    logic              fifo_has_s;
    logic              live_alu_s;
    logic              alu_cand_s;
    logic              lsb_cand_s;
    logic [TAG_W-1:0]  alu_cand_tag_s;
    logic [DATA_W-1:0] alu_cand_val_s;
    logic              go_s;
    logic              alu_win_s;
    logic              lsb_win_s;
    logic              bypass_s;
    logic              push_s;
    logic              pop_s;

    // Candidate selection, arbitration and FIFO push/pop decisions.
    always_comb begin
        fifo_has_s = (count_r != CNT_ZERO);
        live_alu_s = (bus.in_alu_tag != TAG_NONE);
        lsb_cand_s = bus.in_lsb_valid & (bus.in_lsb_tag != TAG_NONE);
        go_s       = bus.rdy & ~bus.in_clear;
        alu_win_s  = 1'b0;
        lsb_win_s  = 1'b0;

        // Queued ALU results are older than the live one, so they go first.
        if (fifo_has_s) begin
            alu_cand_tag_s = fifo_tag_r[head_r];
            alu_cand_val_s = fifo_val_r[head_r];
        end else begin
            alu_cand_tag_s = bus.in_alu_tag;
            alu_cand_val_s = bus.in_alu_value;
        end
        alu_cand_s = fifo_has_s | live_alu_s;

        // A full FIFO must drain, otherwise the unstallable ALU would overflow it.
        if (alu_cand_s && lsb_cand_s) begin
            if ((count_r == CNT_FULL) || (last_grant_r == GNT_LSB)) begin
                alu_win_s = 1'b1;
            end else begin
                lsb_win_s = 1'b1;
            end
        end else if (alu_cand_s) begin
            alu_win_s = 1'b1;
        end else if (lsb_cand_s) begin
            lsb_win_s = 1'b1;
        end else begin
            alu_win_s = 1'b0;
            lsb_win_s = 1'b0;
        end

        // A bypass win broadcasts the live result directly; it must not be queued too.
        bypass_s = alu_win_s & ~fifo_has_s;
        pop_s    = go_s & alu_win_s & fifo_has_s;
        push_s   = go_s & live_alu_s & ~bypass_s;
    end

    // FIFO payload storage; contents are meaningless outside head..tail.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            fifo_tag_r[tail_r] <= bus.in_alu_tag;
            fifo_val_r[tail_r] <= bus.in_alu_value;
        end
    end

    // Control state: pointers, occupancy, fairness bit and the broadcast register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r       <= PTR_ZERO;
            tail_r       <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            last_grant_r <= GNT_LSB;
            cdb_tag_r    <= TAG_NONE;
            cdb_val_r    <= {DATA_W{1'b0}};
        end else if (bus.rdy) begin
            if (bus.in_clear) begin
                head_r       <= PTR_ZERO;
                tail_r       <= PTR_ZERO;
                count_r      <= CNT_ZERO;
                last_grant_r <= GNT_LSB;
                cdb_tag_r    <= TAG_NONE;
            end else begin
                if (pop_s) begin
                    head_r <= ptr_inc(head_r);
                end
                if (push_s) begin
                    tail_r <= ptr_inc(tail_r);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
                if (alu_win_s) begin
                    cdb_tag_r    <= alu_cand_tag_s;
                    cdb_val_r    <= alu_cand_val_s;
                    last_grant_r <= GNT_ALU;
                end else if (lsb_win_s) begin
                    cdb_tag_r    <= bus.in_lsb_tag;
                    cdb_val_r    <= bus.in_lsb_value;
                    last_grant_r <= GNT_LSB;
                end else begin
                    cdb_tag_r    <= TAG_NONE;
                end
            end
        end
    end

    assign bus.out_lsb_grant = go_s & lsb_win_s;
    // Stall one slot early: an ALU op already issued still delivers its result.
    assign bus.out_alu_stall = (count_r >= CNT_STALL);
    assign bus.out_cdb_tag   = cdb_tag_r;
    assign bus.out_cdb_value = cdb_val_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven vectors, hand-written corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } ent_t;

    // Reference model state: queued ALU results in age order, fairness, broadcast.
    ent_t              mq[$];
    logic              m_last_lsb;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_val;
    logic              m_grant;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic dut_grant;
    logic dut_stall;

    // Stimulus helpers for the sequences.
    int                alu_ctr = 0;
    int                lsb_ctr = 0;
    logic              lsb_pend = 1'b0;
    logic [TAG_W-1:0]  lsb_t;
    logic [DATA_W-1:0] lsb_v;
    logic [TAG_W-1:0]  last_alu_tag;

    typedef struct {
        logic              r, rd, cl;
        logic [TAG_W-1:0]  at;
        logic [DATA_W-1:0] av;
        logic              lv;
        logic [TAG_W-1:0]  lt;
        logic [DATA_W-1:0] lval;
        logic              eg;
        logic [TAG_W-1:0]  et;
        logic [DATA_W-1:0] ev;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check grant/stall, then the broadcast.
    task automatic step(input logic r, input logic rd, input logic cl,
                        input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] av,
                        input logic lv, input logic [TAG_W-1:0] lt,
                        input logic [DATA_W-1:0] lval);
        int   win;
        ent_t a;
        logic alu_c, lsb_c, bypass;
        rst              = r;
        bus.rdy          = rd;
        bus.in_clear     = cl;
        bus.in_alu_tag   = at;
        bus.in_alu_value = av;
        bus.in_lsb_valid = lv;
        bus.in_lsb_tag   = lt;
        bus.in_lsb_value = lval;
        #1;
        alu_c = (mq.size() > 0) || (at != '0);
        a     = (mq.size() > 0) ? mq[0] : {at, av};
        lsb_c = lv && (lt != '0);
        if (alu_c && lsb_c) win = (mq.size() == DEPTH || m_last_lsb) ? 1 : 2;
        else if (alu_c)     win = 1;
        else if (lsb_c)     win = 2;
        else                win = 0;
        m_grant   = rd && !cl && (win == 2);
        dut_grant = bus.out_lsb_grant;
        dut_stall = bus.out_alu_stall;
        check("lsb_grant", 64'(dut_grant), 64'(m_grant));
        check("alu_stall", 64'(dut_stall), 64'(mq.size() >= DEPTH - 1));
        @(posedge clk);
        if (!r) begin
            mq.delete();
            m_tag = '0; m_val = '0; m_last_lsb = 1'b1;
        end else if (rd && cl) begin
            mq.delete();
            m_tag = '0; m_last_lsb = 1'b1;
        end else if (rd) begin
            bypass = 1'b0;
            if (win == 1) begin
                m_tag = a.tag; m_val = a.val; m_last_lsb = 1'b0;
                if (mq.size() > 0) void'(mq.pop_front());
                else bypass = 1'b1;
            end else if (win == 2) begin
                m_tag = lt; m_val = lval; m_last_lsb = 1'b1;
            end else begin
                m_tag = '0;
            end
            if (at != '0 && !bypass) mq.push_back({at, av});
        end
        @(negedge clk);
        check("cdb_tag", 64'(bus.out_cdb_tag), 64'(m_tag));
        check("cdb_value", 64'(bus.out_cdb_value), 64'(m_val));
    endtask

    // Cycle with generated traffic: ALU tags 1..11, LSB tags 12..15, LSB held until granted.
    task automatic cycle_auto(input logic r, input logic rd, input logic cl,
                              input logic issue, input logic want_lsb);
        logic [TAG_W-1:0] at;
        at = '0;
        if (issue) begin
            alu_ctr = (alu_ctr % 11) + 1;
            at = TAG_W'(alu_ctr);
        end
        last_alu_tag = at;
        if (!lsb_pend && want_lsb) begin
            lsb_ctr  = (lsb_ctr % 4) + 1;
            lsb_t    = TAG_W'(11 + lsb_ctr);
            lsb_v    = $urandom;
            lsb_pend = 1'b1;
        end
        step(r, rd, cl, at, $urandom, lsb_pend, lsb_pend ? lsb_t : '0, lsb_v);
        if (m_grant || !r || (rd && cl)) lsb_pend = 1'b0;
    endtask

    task automatic do_reset();
        lsb_pend = 1'b0;
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Fill the FIFO with contending traffic until the model holds n entries.
    task automatic fill_to(input int n, input string name);
        int k;
        k = 0;
        while (mq.size() < n && k < 30) begin
            cycle_auto(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            k++;
        end
        check(name, 64'(mq.size() >= n), 64'(1));
    endtask

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   alu_iss[$];
        int   alu_seen[$];
        logic seen_stall;
        logic [TAG_W-1:0]  saved_tag;
        logic [DATA_W-1:0] saved_val;
        int   k;

        // Row fields: rst rdy clr alu_tag alu_val lsb_v lsb_tag lsb_val | grant tag value
        vt[0]  = '{1'b0, 1'b1, 1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 4'd3, 32'h11, 1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 32'h11};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h11};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 4'd2, 32'h22, 1'b1, 4'd5, 32'h55, 1'b0, 4'd2, 32'h22};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 4'd0, 32'h0,  1'b1, 4'd5, 32'h55, 1'b1, 4'd5, 32'h55};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 4'd0, 32'h0,  1'b1, 4'd0, 32'h99, 1'b0, 4'd0, 32'h55};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 4'd7, 32'h77, 1'b1, 4'd6, 32'h66, 1'b0, 4'd7, 32'h77};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 4'd8, 32'h88, 1'b1, 4'd6, 32'h66, 1'b1, 4'd6, 32'h66};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 4'd9, 32'h99, 1'b0, 4'd0, 32'h0,  1'b0, 4'd8, 32'h88};
        vt[10] = '{1'b1, 1'b1, 1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 4'd9, 32'h99};
        vt[11] = '{1'b1, 1'b0, 1'b0, 4'd4, 32'h44, 1'b1, 4'd1, 32'h10, 1'b0, 4'd9, 32'h99};
        vt[12] = '{1'b1, 1'b1, 1'b1, 4'd4, 32'h44, 1'b1, 4'd1, 32'h10, 1'b0, 4'd0, 32'h99};
        vt[13] = '{1'b1, 1'b1, 1'b0, 4'd0, 32'h0,  1'b1, 4'd1, 32'h10, 1'b1, 4'd1, 32'h10};

        // Bring the design out of its unknown power-up state before checking.
        rst = 1'b0; bus.rdy = 1'b1; bus.in_clear = 1'b0;
        bus.in_alu_tag = '0; bus.in_alu_value = '0;
        bus.in_lsb_valid = 1'b0; bus.in_lsb_tag = '0; bus.in_lsb_value = '0;
        @(negedge clk);
        @(negedge clk);
        mq.delete(); m_tag = '0; m_val = '0; m_last_lsb = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vt[i].r, vt[i].rd, vt[i].cl, vt[i].at, vt[i].av,
                 vt[i].lv, vt[i].lt, vt[i].lval);
            check($sformatf("tbl%0d_grant", i), 64'(dut_grant), 64'(vt[i].eg));
            check($sformatf("tbl%0d_tag", i), 64'(bus.out_cdb_tag), 64'(vt[i].et));
            check($sformatf("tbl%0d_value", i), 64'(bus.out_cdb_value), 64'(vt[i].ev));
        end

        // Sustained ALU traffic against a busy LSB: stall appears, order preserved.
        do_reset();
        seen_stall = 1'b0;
        k = 0;
        while (k < 40 && (k < 12 || mq.size() > 0 || lsb_pend)) begin
            cycle_auto(1'b1, 1'b1, 1'b0, (k < 12) && (mq.size() < DEPTH - 1), k < 6);
            if (last_alu_tag != '0) alu_iss.push_back(int'(last_alu_tag));
            if (bus.out_cdb_tag != '0 && bus.out_cdb_tag < 4'd12)
                alu_seen.push_back(int'(bus.out_cdb_tag));
            seen_stall = seen_stall | dut_stall;
            k++;
        end
        check("seq_stall_seen", 64'(seen_stall), 64'(1));
        check("seq_alu_count", 64'(alu_seen.size()), 64'(alu_iss.size()));
        for (int i = 0; i < alu_iss.size() && i < alu_seen.size(); i++)
            check($sformatf("seq_alu_order%0d", i), 64'(alu_seen[i]), 64'(alu_iss[i]));

        // Flush with two queued entries: nothing queued is ever broadcast.
        do_reset();
        fill_to(2, "clr_fill");
        cycle_auto(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_tag", 64'(bus.out_cdb_tag), 64'(0));
        check("clr_stall", 64'(bus.out_alu_stall), 64'(0));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
            check($sformatf("clr_idle%0d", i), 64'(bus.out_cdb_tag), 64'(0));
        end

        // rdy low freezes everything, then broadcasting resumes.
        do_reset();
        fill_to(2, "rdy_fill");
        saved_tag = m_tag;
        saved_val = m_val;
        for (int i = 0; i < 3; i++) begin
            cycle_auto(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            check($sformatf("rdy_grant%0d", i), 64'(dut_grant), 64'(0));
            check($sformatf("rdy_tag%0d", i), 64'(bus.out_cdb_tag), 64'(saved_tag));
            check($sformatf("rdy_value%0d", i), 64'(bus.out_cdb_value), 64'(saved_val));
        end
        cycle_auto(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rdy_resume", 64'(bus.out_cdb_tag != '0), 64'(1));

        // Reset while full drops everything.
        do_reset();
        fill_to(DEPTH, "rst_fill");
        cycle_auto(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_tag", 64'(bus.out_cdb_tag), 64'(0));
        check("rst_value", 64'(bus.out_cdb_value), 64'(0));
        check("rst_stall", 64'(bus.out_alu_stall), 64'(0));
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        check("rst_drop", 64'(bus.out_cdb_tag), 64'(0));

        // Randomized traffic against the model; the bench honours the model's stall.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            cycle_auto($urandom_range(99) != 0, $urandom_range(9) != 0,
                       $urandom_range(29) == 0,
                       (mq.size() < DEPTH - 1) && ($urandom_range(9) < 6),
                       $urandom_range(9) < 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 32, result value width.
  TAG_W, 4, ROB tag width; tag 0 means "no result".
  DEPTH, 4, ALU skid FIFO depth.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on its rising edge.
  rst  in  1  synchronous reset, active-low (rst==0 resets on the rising edge of clk).
  rdy  in  1  global enable; state holds when 0.
  in_clear  in  1  pipeline flush (misprediction); active high.
  in_alu_tag  in  TAG_W  ALU result tag; nonzero = valid this cycle; cannot be stalled.
  in_alu_value  in  DATA_W  ALU result value.
  in_lsb_valid  in  1  load/store buffer result pending; held until granted.
  in_lsb_tag  in  TAG_W  LSB result tag.
  in_lsb_value  in  DATA_W  LSB result value.
  out_lsb_grant  out  1  combinational; LSB result accepted this cycle.
  out_alu_stall  out  1  registered-count based; RS shall not issue while 1.
  out_cdb_tag  out  TAG_W  registered broadcast tag; 0 = idle.
  out_cdb_value  out  DATA_W  registered broadcast value.

Function
REQ-003 The block SHALL contain a DEPTH-entry ALU FIFO (tag+value) with head pointer, tail pointer and count (0..DEPTH); pointers SHALL wrap modulo DEPTH.
REQ-004 The ALU candidate SHALL be the FIFO head when count>0, otherwise the live in_alu_tag/in_alu_value when in_alu_tag!=0 (bypass); otherwise there is no ALU candidate.
REQ-005 The LSB candidate SHALL exist iff in_lsb_valid==1 and in_lsb_tag!=0.
REQ-006 Arbitration SHALL be combinational each cycle: a single candidate wins; with two candidates, ALU wins if count==DEPTH, else the requester not recorded in last_grant wins.
REQ-007 last_grant SHALL update to the winner on every edge on which a grant occurs (rdy==1, in_clear==0); otherwise it holds.
REQ-008 out_lsb_grant SHALL be 1 iff rdy==1, in_clear==0 and the LSB wins.
REQ-009 On each edge with rdy==1 and in_clear==0, the winner's tag/value SHALL be registered onto out_cdb_tag/out_cdb_value; with no winner, out_cdb_tag SHALL become 0 and out_cdb_value SHALL hold.
REQ-010 Each ALU result SHALL be broadcast exactly once: a bypass win consumes the live input without a push; otherwise a live nonzero in_alu_tag SHALL be pushed at the tail, and a FIFO-head win SHALL pop the head.
REQ-011 A simultaneous push and pop SHALL leave count unchanged; a push with count==DEPTH cannot occur without a pop, because REQ-006 forces the ALU win.
REQ-012 out_alu_stall SHALL equal (count >= DEPTH-1), so the RS stops issuing with one slot spare for the in-flight ALU result.
REQ-013 Latency SHALL be one edge: an uncontended ALU or LSB result presented in cycle N SHALL appear on out_cdb_* in cycle N+1.
REQ-014 in_clear==1 with rdy==1 SHALL empty the FIFO, set out_cdb_tag to 0, set last_grant to LSB and deassert out_lsb_grant; inputs in that cycle SHALL be discarded.
REQ-015 With rdy==0 all registers SHALL hold, inputs SHALL be ignored and out_lsb_grant SHALL be 0.

Reset
REQ-016 On a rising edge with rst==0: out_cdb_tag=0, out_cdb_value=0, FIFO empty (head=tail=count=0), last_grant=LSB (the first tie goes to ALU), out_alu_stall=0.
REQ-017 Reset SHALL take priority over rdy and in_clear; a reset mid-operation SHALL drop all FIFO contents and any pending broadcast.

Verification
REQ-018 Reset, then ALU tag 3 / value 0x11 alone in cycle N -> out_cdb_tag=3 and value=0x11 in cycle N+1, tag 0 in cycle N+2, count stays 0.
REQ-019 ALU tag 2 and LSB tag 5 valid in the same cycle after reset -> ALU broadcast first (grant 0), tag 5 next cycle (grant 1), no loss.
REQ-020 ALU results every cycle plus LSB held valid for 6 cycles -> alternating broadcasts, out_alu_stall=1 at count 3, count never exceeds 4, all tags broadcast once in order per source.
REQ-021 FIFO holding 2 entries, in_clear=1 -> next cycle out_cdb_tag=0, count=0, out_alu_stall=0; earlier entries never broadcast.
REQ-022 rdy=0 for 3 cycles with FIFO count 2 and LSB valid -> outputs and count frozen, grant 0; broadcasting resumes on the first edge after rdy=1.
REQ-023 rst=0 asserted while the FIFO is full -> next cycle all outputs at their reset values and count=0.
